// File: rtl/move_pkg.sv
// move_pkg: shared direction encodings, scheduler state enum and default speed-ramp constants
package move_pkg;
  localparam logic [1:0] DIR_A = 2'd0;
  localparam logic [1:0] DIR_D = 2'd1;
  localparam logic [1:0] DIR_W = 2'd2;
  localparam logic [1:0] DIR_S = 2'd3;
  localparam int MAX_SPEED_DEF = 4;
  localparam int RAMP_FRAMES_DEF = 8;
  typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin pick (mask, last -> grant, any), searching from last+1 with wrap
module rr_arbiter4
  import move_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       any
);
  always_comb begin
    grant = DIR_A;
    for (int i = 4; i >= 1; i--)
      if (mask[last + 2'(i)]) grant = last + 2'(i);
  end
  assign any = |mask;
endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: per-frame round-robin step scheduler with hold-time speed ramp over valid/ready; OPPOSE_CANCEL_EN cancels opposing keys
module move_scheduler
  import move_pkg::*;
#(
  parameter int MAX_SPEED   = MAX_SPEED_DEF,
  parameter int RAMP_FRAMES = RAMP_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       key_a,
  input  logic       key_d,
  input  logic       key_w,
  input  logic       key_s,
  input  logic       step_ready,
  output logic       step_valid,
  output logic [1:0] step_dir,
  output logic [2:0] speed,
  output logic       busy,
  output logic       overrun
);
  state_t     state, state_n;
  logic [3:0] mask, mask_n, key_mask;
  logic [1:0] last_grant, last_n, grant;
  logic [7:0] hold_cnt, hold_n, hold_inc;
  logic [2:0] speed_n, budget, budget_n;
  logic       any, ramp, active;
`ifdef OPPOSE_CANCEL_EN
  assign key_mask = {{2{~(key_w & key_s)}} & {key_s, key_w}, {2{~(key_a & key_d)}} & {key_d, key_a}};
`else
  assign key_mask = {key_s, key_w, key_d, key_a};
`endif
  assign active   = |key_mask;
  assign hold_inc = hold_cnt + 8'd1;
  assign ramp     = hold_inc == 8'(RAMP_FRAMES);
  rr_arbiter4 u_arb (.mask(mask), .last(last_grant), .grant(grant), .any(any));
  assign step_valid = state == ISSUE && any;
  assign busy       = step_valid;
  assign step_dir   = step_valid ? grant : DIR_A;
  always_comb begin
    state_n  = state;
    mask_n   = mask;
    last_n   = last_grant;
    hold_n   = hold_cnt;
    speed_n  = speed;
    budget_n = budget;
    if (state == IDLE && frame_tick) begin
      mask_n   = key_mask;
      hold_n   = active && !ramp ? hold_inc : 8'd0;
      speed_n  = !active ? 3'd1 : (ramp && speed < 3'(MAX_SPEED)) ? speed + 3'd1 : speed;
      budget_n = active ? speed_n : 3'd0;
      state_n  = active ? ISSUE : IDLE;
    end else if (state == ISSUE && step_ready) begin
      last_n   = grant;
      budget_n = budget - 3'd1;
      state_n  = budget == 3'd1 ? IDLE : ISSUE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= 4'd0;
      last_grant <= DIR_S;
      hold_cnt   <= 8'd0;
      speed      <= 3'd1;
      budget     <= 3'd0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      mask       <= mask_n;
      last_grant <= last_n;
      hold_cnt   <= hold_n;
      speed      <= speed_n;
      budget     <= budget_n;
      overrun    <= state == ISSUE && frame_tick;
    end
  end
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: table-driven frame vectors with a step-direction scoreboard plus stall, overrun and mid-burst reset sequences
module tb_move_scheduler;
  logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, step_ready = 1'b1;
  logic key_a = 1'b0, key_d = 1'b0, key_w = 1'b0, key_s = 1'b0;
  logic step_valid, busy, overrun;
  logic [1:0] step_dir;
  logic [2:0] speed;
  int checks = 0, fails = 0, hs = 0;
  logic [1:0] exp_q[$];
  typedef struct {
    logic       r;
    logic [3:0] k;
    logic [2:0] spd;
    int         n;
    logic [7:0] dirs;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  move_scheduler dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .key_a(key_a), .key_d(key_d), .key_w(key_w), .key_s(key_s),
    .step_ready(step_ready), .step_valid(step_valid), .step_dir(step_dir),
    .speed(speed), .busy(busy), .overrun(overrun)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (step_valid && step_ready) begin
      hs++;
      if (exp_q.size() == 0) chk("unexpected_step", 1, 0);
      else chk("step_dir", step_dir, exp_q.pop_front());
    end
  function automatic void add(input logic r, input logic [3:0] k, input logic [2:0] spd, input int n, input logic [7:0] dirs);
    vec_t v;
    v.r = r; v.k = k; v.spd = spd; v.n = n; v.dirs = dirs;
    vq.push_back(v);
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    {key_s, key_w, key_d, key_a} = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", step_valid, 0);
    chk("rst_dir", step_dir, 0);
    chk("rst_speed", speed, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
  endtask
  task automatic do_tick(input logic [3:0] k, input logic [2:0] spd, input int n, input logic [7:0] dirs);
    int h0, w;
    {key_s, key_w, key_d, key_a} = k;
    for (int i = 0; i < n; i++) exp_q.push_back(dirs[2*i +: 2]);
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    h0 = hs;
    @(negedge clk);
    chk("valid_t1", step_valid, n > 0);
    chk("busy_t1", busy, n > 0);
    chk("speed", speed, spd);
    w = 0;
    while (step_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("burst_len", hs - h0, n);
    chk("burst_cycles", w, n);
    chk("queue_empty", exp_q.size(), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int h0;
    add(1, 4'b0001, 1, 1, 8'h00);
    add(0, 4'b0000, 1, 0, 8'h00);
    add(1, 4'b0101, 1, 1, 8'h00);
    add(0, 4'b0101, 1, 1, 8'h02);
    add(0, 4'b0101, 1, 1, 8'h00);
    add(0, 4'b0101, 1, 1, 8'h02);
    for (int t = 1; t <= 32; t++)
      add(t == 1, 4'b0010, t < 8 ? 3'd1 : t < 16 ? 3'd2 : t < 24 ? 3'd3 : 3'd4,
          t < 8 ? 1 : t < 16 ? 2 : t < 24 ? 3 : 4, 8'h55);
    add(0, 4'b0000, 1, 0, 8'h00);
    add(0, 4'b0010, 1, 1, 8'h01);
`ifdef OPPOSE_CANCEL_EN
    add(1, 4'b0011, 1, 0, 8'h00);
    add(0, 4'b0011, 1, 0, 8'h00);
    add(0, 4'b1100, 1, 0, 8'h00);
`else
    add(1, 4'b0011, 1, 1, 8'h00);
    add(0, 4'b0011, 1, 1, 8'h01);
    add(0, 4'b0011, 1, 1, 8'h00);
`endif
    foreach (vq[i]) begin
      if (vq[i].r) do_reset();
      do_tick(vq[i].k, vq[i].spd, vq[i].n, vq[i].dirs);
    end
    do_reset();
    for (int t = 1; t <= 7; t++) do_tick(4'b0010, 1, 1, 8'h01);
    step_ready = 1'b0;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    h0 = hs;
    @(negedge clk);
    chk("stall_start_valid", step_valid, 1);
    chk("stall_speed", speed, 2);
    for (int i = 0; i < 5; i++) begin
      frame_tick = (i == 1);
      @(posedge clk);
      #1 frame_tick = 1'b0;
      @(negedge clk);
      chk("stall_valid", step_valid, 1);
      chk("stall_dir", step_dir, 1);
      chk("overrun", overrun, i == 1);
    end
    chk("stall_speed_kept", speed, 2);
    step_ready = 1'b1;
    for (int w = 0; w < 20 && step_valid; w++) @(negedge clk);
    chk("stall_burst_len", hs - h0, 2);
    chk("stall_queue_empty", exp_q.size(), 0);
    do_tick(4'b0010, 2, 2, 8'h05);
    do_reset();
    for (int t = 1; t <= 15; t++) do_tick(4'b0010, t < 8 ? 3'd1 : 3'd2, t < 8 ? 1 : 2, 8'h05);
    step_ready = 1'b0;
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", step_valid, 1);
    chk("pre_rst_speed", speed, 3);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", step_valid, 0);
    chk("midrst_speed", speed, 1);
    chk("midrst_busy", busy, 0);
    step_ready = 1'b1;
    do_tick(4'b1000, 1, 1, 8'h03);
    do_tick(4'b0000, 1, 0, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/move_scheduler.md
# move_scheduler

Schedules sprite movement commands between the keyboard decoder and the sprite position register. Once per frame it samples the held direction keys (A/D/W/S), arbitrates among them round-robin and issues a per-frame budget of single-step commands over a valid/ready handshake. A hold-time speed ramp raises the budget the longer any key stays held. Diagonal and multi-key movement therefore advance fairly instead of under fixed key priority.

## Interface
- MAX_SPEED, 4: maximum steps issued per frame; legal range 1..7.
- RAMP_FRAMES, 8: consecutive active frames needed per speed increment; legal range 1..255.

- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse, once per frame.
- key_a, key_d, key_w, key_s  input  1 each  level "key held" from the keyboard decoder.
- step_ready  input  1  position datapath accepts a step.
- step_valid  output  1  step command present.
- step_dir  output  2  0=A, 1=D, 2=W, 3=S.
- speed  output  3  current steps-per-frame budget.
- busy  output  1  burst in progress; equals step_valid.
- overrun  output  1  one-cycle pulse: frame_tick dropped.

## Operation
- Reset values: step_valid=0, step_dir=0, speed=1, busy=0, overrun=0, last_grant=3 (first grant searches from A), hold_cnt=0, budget=0.
- The block has two states, IDLE and ISSUE.
- **IDLE behaviour on frame_tick:**
  - Latch mask = {key_s, key_w, key_d, key_a}, with opposing-key filtering applied (see Configuration).
  - Mask non-empty:
    - hold_cnt increments.
    - When hold_cnt reaches RAMP_FRAMES, hold_cnt clears and speed increments, saturating at MAX_SPEED.
    - The speed update takes effect in this same tick's budget: budget = updated speed.
    - Go to ISSUE.
  - Mask empty: speed=1, hold_cnt=0, stay in IDLE.
- **ISSUE behaviour:**
  - step_valid=1.
  - step_dir = first set bit of the mask, searching from (last_grant+1) mod 4 upward with wrap.
  - Handshake occurs when step_valid && step_ready on a rising edge. On a handshake:
    - last_grant = step_dir.
    - budget decrements.
    - If budget becomes 0, go to IDLE (step_valid=0 next cycle).
    - Otherwise step_valid stays high and step_dir advances to the next grant on the following cycle.
  - While step_ready=0, step_valid and step_dir hold stable.
- Keys are sampled only at frame_tick. Key changes during a burst are ignored.
- frame_tick in ISSUE: the tick is dropped, overrun pulses high for one cycle, and hold_cnt and speed are untouched.
- Reset mid-burst: all state returns to reset values on that edge. The partial burst is discarded.
- budget width is 3 bits, and speed never exceeds MAX_SPEED.

## Timing
- frame_tick at cycle T (IDLE, keys held): step_valid=1 at T+1.
- With step_ready held high, a burst of N steps occupies cycles T+1..T+N, one step per cycle. step_valid=0 at T+N+1.
- Back-to-back grants have no bubble cycle.
- overrun asserts in the cycle after the dropped tick.
- speed changes in the cycle after the qualifying tick, together with the first step_valid.

## Configuration
- OPPOSE_CANCEL_EN
  - Defined: A and D both held clears both mask bits; W and S both held clears both. A mask left empty by this filtering behaves as no keys held: speed resets to 1 and no steps are issued.
  - Undefined: opposing keys stay in the mask and are granted round-robin, so the net position jitters in place.

## Structure
- Shared package move_pkg holds:
  - DIR_A/DIR_D/DIR_W/DIR_S 2-bit encodings, also used by the position datapath.
  - The state enum (IDLE, ISSUE).
  - Default MAX_SPEED/RAMP_FRAMES constants.
- Sub-module rr_arbiter4: combinational 4-way round-robin pick from mask and last_grant. Outputs grant index and any-valid.

## Test plan
1. Reset, key_a=1, tick, step_ready=1 → step_valid=1 dir=0 for exactly one cycle (T+1), speed=1.
2. key_a=key_w=1, four ticks at speed 1 → step_dir sequence 0,2,0,2.
3. key_d held over 8 ticks (RAMP_FRAMES=8) → speed=2 after the 8th tick, and that tick issues two steps.
   - Continue to 32 ticks → speed saturates at 4, 4 steps per tick.
   - Release → next tick speed=1, no step.
4. step_ready=0 for 5 cycles mid-burst → step_valid and step_dir stable.
   - A frame_tick during the stall → overrun pulse, burst count unchanged.
5. key_a=key_d=1:
   - With OPPOSE_CANCEL_EN → no step_valid, speed=1.
   - Without the macro → dirs alternate 0,1 across ticks.
6. rst asserted during ISSUE with budget 3 → next cycle step_valid=0, speed=1, busy=0.
   - Next tick with key_s → dir=3 granted first.
